// File: rtl/polygon_vertex_buffer.sv
// Double-buffered polygon vertex store feeding in_polygon.
// Vertices stream into a back buffer; the front buffer only changes at a frame-start strobe.
module polygon_vertex_buffer #(
    parameter int MAX_NUM_VERTICES = 8,
    parameter int MIN_NUM_VERTICES = 3,
    localparam int CW = $clog2(MAX_NUM_VERTICES + 1),
    localparam int AW = $clog2(MAX_NUM_VERTICES)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic signed [31:0]   vert_x_in,
    input  logic signed [31:0]   vert_y_in,
    input  logic                 vert_valid_in,
    input  logic                 vert_last_in,
    output logic                 vert_ready_out,
    input  logic                 frame_start_in,
    output logic signed [31:0]   xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]   ys_out [MAX_NUM_VERTICES],
    output logic [CW-1:0]        num_points_out,
    output logic                 swapped_out,
    output logic                 error_out
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count, count_next;
    logic [CW-1:0]      back_count;
    logic signed [31:0] back_x [MAX_NUM_VERTICES];
    logic signed [31:0] back_y [MAX_NUM_VERTICES];

    logic xfer;
    logic wr_en;
    logic latch_count;
    logic do_swap;
    logic reject;

    assign vert_ready_out = (state != FULL);
    assign xfer           = vert_valid_in && vert_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= FILL;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // The overflow check on count == MAX comes first so count never wraps.
    always_comb begin
        state_next  = state;
        count_next  = count;
        wr_en       = 1'b0;
        latch_count = 1'b0;
        do_swap     = 1'b0;
        reject      = 1'b0;
        unique case (state)
            FILL: begin
                if (xfer) begin
                    if (int'(count) == MAX_NUM_VERTICES) begin
                        if (vert_last_in) begin
                            reject     = 1'b1;
                            count_next = '0;
                        end else begin
                            state_next = DROP;
                        end
                    end else if (vert_last_in) begin
                        if (int'(count) + 1 < MIN_NUM_VERTICES) begin
                            reject     = 1'b1;
                            count_next = '0;
                        end else begin
                            wr_en       = 1'b1;
                            latch_count = 1'b1;
                            state_next  = FULL;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        count_next = count + CW'(1);
                    end
                end
            end
            DROP: begin
                if (xfer && vert_last_in) begin
                    reject     = 1'b1;
                    count_next = '0;
                    state_next = FILL;
                end
            end
            FULL: begin
                if (frame_start_in) begin
                    do_swap    = 1'b1;
                    count_next = '0;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                count_next = '0;
            end
        endcase
    end

    // Slots above back_count are copied untouched; num_points_out tells in_polygon to ignore them.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                back_x[i] <= '0;
                back_y[i] <= '0;
                xs_out[i] <= '0;
                ys_out[i] <= '0;
            end
            back_count     <= '0;
            num_points_out <= '0;
            swapped_out    <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            swapped_out <= do_swap;
            error_out   <= reject;
            if (wr_en) begin
                back_x[count[AW-1:0]] <= vert_x_in;
                back_y[count[AW-1:0]] <= vert_y_in;
            end
            if (latch_count) begin
                back_count <= count + CW'(1);
            end
            if (do_swap) begin
                for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                    xs_out[i] <= back_x[i];
                    ys_out[i] <= back_y[i];
                end
                num_points_out <= back_count;
            end
        end
    end

endmodule

// File: tb/tb_polygon_vertex_buffer.sv
// Bench for polygon_vertex_buffer: directed scenarios plus random polygons against a
// queue-based model of whole polygons, pending back buffer and displayed front buffer.
module tb_polygon_vertex_buffer;

    localparam int MAXV = 8;
    localparam int MINV = 3;
    localparam int CW   = $clog2(MAXV + 1);

    logic                clk_in;
    logic                rst_n_in;
    logic signed [31:0]  vert_x_in;
    logic signed [31:0]  vert_y_in;
    logic                vert_valid_in;
    logic                vert_last_in;
    logic                vert_ready_out;
    logic                frame_start_in;
    logic signed [31:0]  xs_out [MAXV];
    logic signed [31:0]  ys_out [MAXV];
    logic [CW-1:0]       num_points_out;
    logic                swapped_out;
    logic                error_out;

    int checks   = 0;
    int failures = 0;

    int front_x [MAXV];
    int front_y [MAXV];
    int front_n;
    int pend_x [$];
    int pend_y [$];
    bit pending;
    int cur_x [$];
    int cur_y [$];

    polygon_vertex_buffer #(
        .MAX_NUM_VERTICES(MAXV),
        .MIN_NUM_VERTICES(MINV)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .vert_x_in      (vert_x_in),
        .vert_y_in      (vert_y_in),
        .vert_valid_in  (vert_valid_in),
        .vert_last_in   (vert_last_in),
        .vert_ready_out (vert_ready_out),
        .frame_start_in (frame_start_in),
        .xs_out         (xs_out),
        .ys_out         (ys_out),
        .num_points_out (num_points_out),
        .swapped_out    (swapped_out),
        .error_out      (error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXV; i++) begin
            front_x[i] = 0;
            front_y[i] = 0;
        end
        front_n = 0;
        pending = 1'b0;
        pend_x.delete();
        pend_y.delete();
        cur_x.delete();
        cur_y.delete();
    endtask

    task automatic check_reset_state();
        check_output("rst_ready", 32'(vert_ready_out), 32'd1);
        check_output("rst_swapped", 32'(swapped_out), 32'd0);
        check_output("rst_error", 32'(error_out), 32'd0);
        check_output("rst_num_points", 32'(num_points_out), 32'd0);
        for (int i = 0; i < MAXV; i++) begin
            check_output($sformatf("rst_xs[%0d]", i), xs_out[i], 32'd0);
            check_output($sformatf("rst_ys[%0d]", i), ys_out[i], 32'd0);
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, then compare #1 after it.
    task automatic apply_stimulus(input bit v, input int x, input int y, input bit l, input bit fs,
                                  output bit xfer);
        bit exp_swap;
        bit exp_err;
        bit swap_now;
        exp_swap = 1'b0;
        exp_err  = 1'b0;
        vert_valid_in  = v;
        vert_x_in      = x;
        vert_y_in      = y;
        vert_last_in   = l;
        frame_start_in = fs;
        xfer     = v && !pending;
        swap_now = fs && pending;
        if (swap_now) begin
            foreach (pend_x[i]) begin
                front_x[i] = pend_x[i];
                front_y[i] = pend_y[i];
            end
            front_n  = pend_x.size();
            pending  = 1'b0;
            exp_swap = 1'b1;
        end
        if (xfer) begin
            cur_x.push_back(x);
            cur_y.push_back(y);
            if (l) begin
                if (cur_x.size() >= MINV && cur_x.size() <= MAXV) begin
                    pend_x  = cur_x;
                    pend_y  = cur_y;
                    pending = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
                cur_x.delete();
                cur_y.delete();
            end
        end
        @(posedge clk_in);
        #1;
        vert_valid_in  = 1'b0;
        vert_last_in   = 1'b0;
        frame_start_in = 1'b0;
        check_output("ready", 32'(vert_ready_out), 32'(!pending));
        check_output("swapped", 32'(swapped_out), 32'(exp_swap));
        check_output("error", 32'(error_out), 32'(exp_err));
        check_output("num_points", 32'(num_points_out), 32'(front_n));
        for (int i = 0; i < front_n; i++) begin
            check_output($sformatf("xs[%0d]", i), xs_out[i], front_x[i]);
            check_output($sformatf("ys[%0d]", i), ys_out[i], front_y[i]);
        end
    endtask

    task automatic idle(input bit fs);
        bit t;
        apply_stimulus(1'b0, 0, 0, 1'b0, fs, t);
    endtask

    task automatic beat(input int x, input int y, input bit l, input bit fs);
        bit t;
        apply_stimulus(1'b1, x, y, l, fs, t);
    endtask

    // Holds a beat until it transfers; a frame strobe is forced after a few stalls.
    task automatic send_beat(input int x, input int y, input bit l);
        bit t;
        bit fs;
        t = 1'b0;
        for (int k = 0; k < 8 && !t; k++) begin
            fs = (k >= 4) || ($urandom_range(0, 3) == 0);
            apply_stimulus(1'b1, x, y, l, fs, t);
        end
        check_output("beat_transfer_bound", 32'(t), 32'd1);
    endtask

    int penta_x [5] = '{700, 700, 800, 900, 900};
    int penta_y [5] = '{250, 150, 50, 150, 250};
    int sq_x [4]    = '{100, 100, 200, 200};
    int sq_y [4]    = '{100, 200, 200, 100};

    initial begin
        vert_valid_in  = 1'b0;
        vert_last_in   = 1'b0;
        vert_x_in      = '0;
        vert_y_in      = '0;
        frame_start_in = 1'b0;
        rst_n_in       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_state();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] pentagon");
        for (int i = 0; i < 5; i++) beat(penta_x[i], penta_y[i], i == 4, 1'b0);
        idle(1'b0);
        beat(1, 2, 1'b1, 1'b0);
        idle(1'b1);
        check_output("penta_num_points", 32'(num_points_out), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_output("penta_xs", xs_out[i], penta_x[i]);
            check_output("penta_ys", ys_out[i], penta_y[i]);
        end
        idle(1'b0);

        $display("[TB] overflow 9 and 12 beats");
        for (int i = 0; i < 9; i++) beat(i * 3, -i, i == 8, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 12; i++) beat(-i, i * 7, i == 11, 1'b0);
        idle(1'b1);
        check_output("overflow_front_kept", 32'(num_points_out), 32'd5);

        $display("[TB] short polygon");
        beat(5, 5, 1'b0, 1'b0);
        beat(6, 6, 1'b1, 1'b0);
        idle(1'b1);

        $display("[TB] last beat with frame start");
        beat(11, 21, 1'b0, 1'b0);
        beat(12, 22, 1'b0, 1'b0);
        beat(13, 23, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b1);
        check_output("simul_num_points", 32'(num_points_out), 32'd3);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) beat(penta_x[i], penta_y[i], 1'b0, 1'b0);
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) beat(sq_x[i], sq_y[i], i == 3, 1'b0);
        idle(1'b1);
        check_output("square_num_points", 32'(num_points_out), 32'd4);
        check_output("square_xs2", xs_out[2], 32'd200);
        check_output("square_ys3", ys_out[3], 32'd100);

        $display("[TB] random polygons");
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                send_beat(int'($urandom), int'($urandom), i == len - 1);
                if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 1) == 0) idle(1'b1);
        end
        idle(1'b1);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
